rf_write_arbiter: RTL and testbench

Controller for the 32x32 register file's single write port (wn/wd/w). After reset it clears every register by walking all addresses. It then shares the port between two writeback requesters (req0 = ALU, req1 = load unit) using round-robin arbitration and a valid/ready handshake. It also counts contention cycles for performance debug.

---
 rtl/rf_write_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port controller with init sweep and round-robin arbitration
//
// Purpose:
//   Owns the single RF write port. After reset it writes INIT_VALUE to every
//   address 0..NREG-1, one address per cycle. It then shares the port between
//   two writeback requesters (req0 = ALU, req1 = load unit) using round-robin
//   arbitration, and counts the RUN cycles in which both requesters were valid.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_valid/wn/wd, req0_ready  requester 0 write handshake
//   req1_valid/wn/wd, req1_ready  requester 1 write handshake
//   rf_wn, rf_wd, rf_w            RF write address / data / enable
//   init_done                     high once the init sweep has completed
//   conflict_cnt                  saturating count of contention cycles

module rf_write_arbiter #(
    parameter int            NREG       = 32,
    parameter int            AW         = 5,
    parameter int            DW         = 32,
    parameter logic [DW-1:0] INIT_VALUE = '0,
    parameter bit            ZERO_REG   = 1'b1,
    parameter int            CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_wn,
    input  logic [DW-1:0] req0_wd,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_wn,
    input  logic [DW-1:0] req1_wd,
    output logic          req1_ready,
    output logic [AW-1:0] rf_wn,
    output logic [DW-1:0] rf_wd,
    output logic          rf_w,
    output logic          init_done,
    output logic [CW-1:0] conflict_cnt
);

    // Two-bit encoding so that the unused codes exist and fall back to INIT.
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          prio_q;
    logic [CW-1:0] conflict_cnt_q;

    logic in_init;
    logic in_run;
    logic both_valid;
    logic gnt0;
    logic gnt1;

    always_comb begin
        in_init    = !rst && (state_q == S_INIT);
        in_run     = !rst && (state_q == S_RUN);
        both_valid = req0_valid && req1_valid;

        // prio_q only matters when both are valid; a lone requester always wins.
        gnt0 = in_run && req0_valid && (!req1_valid || !prio_q);
        gnt1 = in_run && req1_valid && (!req0_valid ||  prio_q);

        rf_wn = req0_wn;
        rf_wd = req0_wd;
        rf_w  = 1'b0;

        if (in_init) begin
            rf_w  = 1'b1;
            rf_wn = cnt_q;
            rf_wd = INIT_VALUE;
        end else if (gnt1) begin
            rf_wn = req1_wn;
            rf_wd = req1_wd;
            // x0 writes complete the handshake but never reach the RF.
            rf_w  = !(ZERO_REG && (req1_wn == '0));
        end else if (gnt0) begin
            rf_wn = req0_wn;
            rf_wd = req0_wd;
            rf_w  = !(ZERO_REG && (req0_wn == '0));
        end

        req0_ready   = gnt0;
        req1_ready   = gnt1;
        init_done    = in_run;
        conflict_cnt = conflict_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_INIT;
            cnt_q          <= '0;
            prio_q         <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (gnt0) begin
                        prio_q <= 1'b1;
                    end else if (gnt1) begin
                        prio_q <= 1'b0;
                    end
                    if (both_valid && !(&conflict_cnt_q)) begin
                        conflict_cnt_q <= conflict_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - randomized self-checking bench for rf_write_arbiter

module tb_rf_write_arbiter;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NCYC = 4000;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_wn, req1_wn;
    logic [DW-1:0] req0_wd, req1_wd;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_wd;
    logic          rf_w;
    logic          init_done;
    logic [15:0]   conflict_cnt;

    logic          s_req0_ready, s_req1_ready;
    logic [AW-1:0] s_rf_wn;
    logic [DW-1:0] s_rf_wd;
    logic          s_rf_w;
    logic          s_init_done;
    logic [3:0]    s_conflict_cnt;

    rf_write_arbiter #(.CW(16)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wn(req0_wn), .req0_wd(req0_wd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_wn(req1_wn), .req1_wd(req1_wd), .req1_ready(req1_ready),
        .rf_wn(rf_wn), .rf_wd(rf_wd), .rf_w(rf_w),
        .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    rf_write_arbiter #(.CW(4)) u_dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wn(req0_wn), .req0_wd(req0_wd), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_wn(req1_wn), .req1_wd(req1_wd), .req1_ready(s_req1_ready),
        .rf_wn(s_rf_wn), .rf_wd(s_rf_wd), .rf_w(s_rf_w),
        .init_done(s_init_done), .conflict_cnt(s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file as seen through the DUT's write port.
    logic [DW-1:0] dut_mem [NREG];
    always @(posedge clk) begin
        if (rf_w) dut_mem[rf_wn] <= rf_wd;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain counters and an array describing the RF contents.
    int            init_cnt;
    int            pref;
    int            conf;
    logic [DW-1:0] mem [NREG];

    // Requester stimulus state.
    logic          pv   [2];
    logic [AW-1:0] pwn  [2];
    logic [DW-1:0] pwd  [2];

    function automatic logic [AW-1:0] rand_wn();
        if ($urandom_range(0, 7) == 0) return '0;
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    task automatic new_req(input int i, input bit force_valid);
        pv[i]  = force_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
        pwn[i] = rand_wn();
        pwd[i] = $urandom;
    endtask

    initial begin
        int rst_left;
        int g;
        bit force_both;
        logic e_w, e_r0, e_r1, e_done;
        logic [AW-1:0] e_wn;
        logic [DW-1:0] e_wd;

        rst = 1'b1;
        req0_valid = 1'b0; req0_wn = '0; req0_wd = '0;
        req1_valid = 1'b0; req1_wn = '0; req1_wd = '0;
        init_cnt = 0; pref = 0; conf = 0; rst_left = 0;
        for (int r = 0; r < NREG; r++) mem[r] = '0;
        new_req(0, 1'b1);
        new_req(1, 1'b1);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            force_both = (cyc >= 3500 && cyc < 3600);
            if (cyc < 2) begin
                rst = 1'b1;
            end else if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else if (cyc < 3300 && $urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst = 1'b0;
            end
            req0_valid = pv[0]; req0_wn = pwn[0]; req0_wd = pwd[0];
            req1_valid = pv[1]; req1_wn = pwn[1]; req1_wd = pwd[1];
            #1;

            check("conflict_cnt", 64'(conflict_cnt), 64'((conf > 65535) ? 65535 : conf));
            check("conflict_cnt_sat", 64'(s_conflict_cnt), 64'((conf > 15) ? 15 : conf));

            g = -1;
            e_wn = req0_wn; e_wd = req0_wd;
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (rst) begin
                e_w = 1'b0; e_done = 1'b0;
            end else if (init_cnt < NREG) begin
                e_w = 1'b1; e_done = 1'b0;
                e_wn = AW'(init_cnt); e_wd = '0;
            end else begin
                e_done = 1'b1;
                if (pv[0] && pv[1]) g = pref;
                else if (pv[0]) g = 0;
                else if (pv[1]) g = 1;
                e_w = 1'b0;
                if (g >= 0) begin
                    e_wn = pwn[g]; e_wd = pwd[g];
                    e_w  = (pwn[g] != 0);
                    e_r0 = (g == 0); e_r1 = (g == 1);
                end
            end

            check("rf_w", 64'(rf_w), 64'(e_w));
            check("rf_wn", 64'(rf_wn), 64'(e_wn));
            check("rf_wd", 64'(rf_wd), 64'(e_wd));
            check("req0_ready", 64'(req0_ready), 64'(e_r0));
            check("req1_ready", 64'(req1_ready), 64'(e_r1));
            check("init_done", 64'(init_done), 64'(e_done));

            // Advance the model to what the coming posedge commits.
            if (rst) begin
                init_cnt = 0; pref = 0; conf = 0;
            end else if (init_cnt < NREG) begin
                mem[init_cnt] = '0;
                init_cnt++;
            end else begin
                if (pv[0] && pv[1]) conf++;
                if (g >= 0) begin
                    if (pwn[g] != 0) mem[pwn[g]] = pwd[g];
                    pref = 1 - g;
                end
            end

            if (g >= 0) new_req(g, force_both);
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && (force_both || $urandom_range(0, 3) == 0)) new_req(i, 1'b1);
            end
        end

        @(negedge clk);
        for (int r = 0; r < NREG; r++) begin
            check($sformatf("rf_mem[%0d]", r), 64'(dut_mem[r]), 64'(mem[r]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
